adder_seq_ctrl: RTL and testbench
=================================

// Module: adder_seq_ctrl
// PURPOSE
//  Sequencer that performs one ADDER_WIDTH-bit addition over several cycles.
//  It uses a single CHUNK_WIDTH-bit adder slice and a registered carry.
//  Operands are accepted through a valid/ready handshake and added chunk by chunk, LSB chunk first.
//  The (ADDER_WIDTH+1)-bit sum is presented through a valid/ready handshake.
//  Used as the area-reduced alternative to the single-cycle wide adder in the arithmetic benchmark set.
// PARAMETERS
//  ADDER_WIDTH  119  operand width in bits; sum is ADDER_WIDTH+1 bits
//  CHUNK_WIDTH  32   width of the adder slice used per cycle; 1 <= CHUNK_WIDTH <= ADDER_WIDTH
//  (derived) NUM_CHUNKS = ceil(ADDER_WIDTH/CHUNK_WIDTH); 4 at defaults; index counter is clog2(NUM_CHUNKS)+1 bits
// PORTS
//  clk        in   1              rising-edge clock, sole clock domain
//  reset      in   1              synchronous, active-high reset
//  in_valid   in   1              a/b valid
//  in_ready   out  1              block can accept operands
//  a          in   ADDER_WIDTH    operand A, unsigned
//  b          in   ADDER_WIDTH    operand B, unsigned
//  out_valid  out  1              sum valid
//  out_ready  in   1              consumer accepts sum
//  sum        out  ADDER_WIDTH+1  a+b, unsigned, includes carry-out
//  busy       out  1              high in ADD or DONE
// BEHAVIOUR
//  Reset (sampled at posedge clk while reset=1)
//   - state=IDLE, chunk index=0, carry=0, result register=0.
//   - Outputs: in_ready=1, out_valid=0, busy=0, sum=0.
//   - Reset dominates every other input in the same cycle.
//   - Reset mid-ADD or mid-DONE aborts the operation; the partial result is discarded and never presented.
//  Operand capture
//   - Operands are zero-extended to NUM_CHUNKS*CHUNK_WIDTH bits and copied into internal registers.
//   - a and b may change freely after acceptance.
//  FSM states: IDLE, ADD, DONE (one-hot or binary at implementer's choice)
//   - IDLE: in_ready=1. If in_valid=1 at the edge: latch operands, carry<=0, idx<=0, go to ADD.
//   - ADD: in_ready=0. Each cycle:
//       {c,s} = A[idx] + B[idx] + carry   (CHUNK_WIDTH-bit slice plus carry-in)
//       R[idx] <= s; carry <= c; idx <= idx+1.
//     After the chunk with idx=NUM_CHUNKS-1, go to DONE with the final carry stored above the top chunk.
//   - DONE: out_valid=1, sum=R[ADDER_WIDTH:0] (padded result truncated to ADDER_WIDTH+1 bits).
//     If out_ready=1 at the edge, go to IDLE; otherwise hold. sum and out_valid are stable while stalled.
//  Outputs and timing
//   - out_valid is a registered output; sum comes straight from the result register.
//   - No combinational path from in_valid or out_ready to any output.
//   - Latency: acceptance at edge T means out_valid=1 in the cycle after edge T+NUM_CHUNKS.
//     That is 4 ADD cycles at defaults.
//   - Throughput: one result per NUM_CHUNKS+2 cycles when out_ready is held high (6 at defaults).
//   - No operand overlap. in_valid is ignored outside IDLE; in_ready=0 in ADD and DONE.
//   - out_valid and in_ready are never both 1.
//  Width rule
//   - When ADDER_WIDTH is not a multiple of CHUNK_WIDTH, the carry into bit ADDER_WIDTH lands inside the padded top chunk.
//   - sum[ADDER_WIDTH] must equal the true carry-out in all cases.
//  Boundary cases
//   - NUM_CHUNKS=1 is legal: one ADD cycle.
//   - out_ready asserted before out_valid has no effect.
// TESTING (defaults W=119, C=32)
//  1 a=1, b=2, out_ready=1 -> sum=3; out_valid exactly 4 cycles after accept, for 1 cycle.
//  2 a=2^119-1, b=1 -> sum=2^119 (bit 119 set, all others 0). Carry ripples through all 4 chunks.
//  3 a=b=2^119-1 -> sum=2^120-2. Then a=0, b=0 -> sum=0 (carry cleared between ops).
//  4 Result ready, out_ready=0 for 10 cycles, in_valid=1 with new operands -> sum and out_valid held,
//    in_ready=0, new operands not taken. Release out_ready -> IDLE next cycle.
//  5 reset=1 for 1 cycle during the idx=2 ADD cycle -> next cycle in_ready=1, out_valid=0, busy=0.
//    Then 5+7 -> sum=12 with no stale data.
//  6 in_valid=1 and out_ready=1 continuously, random operands -> one result every 6 cycles.
//    Every sum matches a+b from the golden model.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: wide unsigned adder computed LSB chunk first through one CHUNK_WIDTH slice and a registered carry
module adder_seq_ctrl #(
   parameter int ADDER_WIDTH = 119,
   parameter int CHUNK_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDER_WIDTH-1:0] a,
   input  logic [ADDER_WIDTH-1:0] b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDER_WIDTH:0]   sum,
   output logic                   busy
);
   localparam int NUM_CHUNKS = (ADDER_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
   localparam int PW = NUM_CHUNKS * CHUNK_WIDTH;
   localparam int IW = $clog2(NUM_CHUNKS) + 1;
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state;
   logic [PW-1:0] a_r, b_r, r;
   logic top, carry;
   logic [IW-1:0] idx;
   logic [CHUNK_WIDTH:0] slice;
   assign slice = {1'b0, a_r[CHUNK_WIDTH-1:0]} + {1'b0, b_r[CHUNK_WIDTH-1:0]} + {{CHUNK_WIDTH{1'b0}}, carry};
   // top only matters when ADDER_WIDTH fills the padded width exactly
   assign sum = (ADDER_WIDTH+1)'({top, r});
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         top       <= 1'b0;
         r         <= '0;
         a_r       <= '0;
         b_r       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r      <= PW'(a);
               b_r      <= PW'(b);
               carry    <= 1'b0;
               idx      <= '0;
               state    <= ADD;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            ADD: begin
               // operands shift down so the active chunk is always at bit 0; results enter from the top
               a_r   <= a_r >> CHUNK_WIDTH;
               b_r   <= b_r >> CHUNK_WIDTH;
               r     <= PW'({slice[CHUNK_WIDTH-1:0], r} >> CHUNK_WIDTH);
               carry <= slice[CHUNK_WIDTH];
               idx   <= idx + IW'(1);
               if (idx == IW'(NUM_CHUNKS - 1)) begin
                  top       <= slice[CHUNK_WIDTH];
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed checks plus a transaction-level model compared every cycle
module tb_adder_seq_ctrl;
   localparam int W = 119;
   localparam int NC = 4;
   logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
   logic [W-1:0] a = '0, b = '0;
   logic in_ready, out_valid, busy;
   logic [W:0] sum;
   int total = 0, bad = 0;
   logic armed = 0;
   adder_seq_ctrl dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   // transaction model: add cycles remaining, result waiting, last completed sum
   int m_add = 0;
   logic m_done = 0;
   logic [W:0] m_sum = '0, m_pend = '0;
   always @(posedge clk) begin
      if (reset) begin
         m_add = 0;
         m_done = 0;
         m_sum = '0;
      end else if (m_done) begin
         if (out_ready) m_done = 0;
      end else if (m_add > 0) begin
         m_add--;
         if (m_add == 0) begin
            m_done = 1;
            m_sum = m_pend;
         end
      end else if (in_valid) begin
         m_add = NC;
         m_pend = {1'b0, a} + {1'b0, b};
      end
   end
   always @(negedge clk) if (armed) begin
      chk("m_in_ready", (W+1)'(in_ready), (W+1)'(!m_done && m_add == 0));
      chk("m_out_valid", (W+1)'(out_valid), (W+1)'(m_done));
      chk("m_busy", (W+1)'(busy), (W+1)'(m_done || m_add != 0));
      if (m_add == 0) chk("m_sum", sum, m_sum);
   end
   task automatic wait_valid(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask
   task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W:0] exp, input string nm);
      int n;
      chk({nm, "_rdy"}, (W+1)'(in_ready), (W+1)'(1));
      a = av;
      b = bv;
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      a = '1;
      b = '1;
      wait_valid(n);
      chk({nm, "_lat"}, (W+1)'(n), (W+1)'(NC));
      chk({nm, "_sum"}, sum, exp);
      if (out_ready) begin
         @(posedge clk); #1;
         chk({nm, "_pulse"}, (W+1)'(out_valid), (W+1)'(0));
      end
   endtask
   initial begin
      logic [W-1:0] ones;
      int n, last, gap;
      logic prev_ov;
      ones = '1;
      @(posedge clk); #1;
      reset = 0;
      armed = 1;
      chk("rst_ready", (W+1)'(in_ready), (W+1)'(1));
      chk("rst_valid", (W+1)'(out_valid), (W+1)'(0));
      chk("rst_busy", (W+1)'(busy), (W+1)'(0));
      chk("rst_sum", sum, '0);
      out_ready = 1;
      op(119'd1, 119'd2, 120'd3, "t1");
      op(ones, 119'd1, {1'b1, 119'd0}, "t2");
      op(ones, ones, {ones, 1'b0}, "t3a");
      op('0, '0, '0, "t3b");
      out_ready = 0;
      op(119'd10, 119'd20, 120'd30, "t4");
      a = 119'd100;
      b = 119'd200;
      in_valid = 1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("t4_hold_sum", sum, 120'd30);
      chk("t4_hold_valid", (W+1)'(out_valid), (W+1)'(1));
      chk("t4_hold_ready", (W+1)'(in_ready), (W+1)'(0));
      out_ready = 1;
      @(posedge clk); #1;
      chk("t4_rel_valid", (W+1)'(out_valid), (W+1)'(0));
      chk("t4_rel_ready", (W+1)'(in_ready), (W+1)'(1));
      @(posedge clk); #1;
      in_valid = 0;
      wait_valid(n);
      chk("t4b_lat", (W+1)'(n), (W+1)'(NC));
      chk("t4b_sum", sum, 120'd300);
      @(posedge clk); #1;
      a = ones;
      b = ones;
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      chk("t5_ready", (W+1)'(in_ready), (W+1)'(1));
      chk("t5_valid", (W+1)'(out_valid), (W+1)'(0));
      chk("t5_busy", (W+1)'(busy), (W+1)'(0));
      chk("t5_sum", sum, '0);
      op(119'd5, 119'd7, 120'd12, "t5b");
      in_valid = 1;
      last = -1;
      prev_ov = 0;
      for (int i = 0; i < 62; i++) begin
         @(posedge clk); #1;
         a = W'({$urandom, $urandom, $urandom, $urandom});
         b = W'({$urandom, $urandom, $urandom, $urandom});
         if (out_valid && !prev_ov) begin
            if (last >= 0) begin
               gap = i - last;
               chk("t6_gap", (W+1)'(gap), (W+1)'(NC + 2));
            end
            last = i;
         end
         prev_ov = out_valid;
      end
      in_valid = 0;
      repeat (8) @(posedge clk);
      #1;
      chk("end_idle", (W+1)'(in_ready), (W+1)'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
